adder_operand_sequencer: RTL and testbench

- Upstream feeder and result capture stage for the 32-bit ripple carry adder on the Tang 20K build.
- Assembles operands A, B and carry-in from an 8-bit valid/ready byte stream (e.g. UART RX) and drives them onto the adder inputs.
- Waits a fixed settle time for the ripple chain, then captures sum and cout.
- Presents the captured result on a valid/ready output handshake.

---
 rtl/adder_operand_sequencer.sv | 155 +++++++++++++++
 tb/tb_adder_operand_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_operand_sequencer.sv
// Byte-stream operand loader and result capture stage for a ripple-carry adder.
// Optional reference self-check is enabled with `define ADDER_SELFCHECK_EN.
module adder_operand_sequencer #(
  parameter int SIZE          = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [SIZE-1:0] add_a,
  output logic [SIZE-1:0] add_b,
  output logic            add_cin,
  input  logic [SIZE-1:0] add_sum,
  input  logic            add_cout,
  output logic [SIZE-1:0] res_sum,
  output logic            res_cout,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            busy,
  output logic            chk_err,
  output logic [2:0]      dbg_state
);

  localparam int NBYTES = SIZE / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int SW     = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_LOAD_A = 3'd0,
    S_LOAD_B = 3'd1,
    S_LOAD_C = 3'd2,
    S_SETTLE = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [SW-1:0]   r_settle;
  logic [SIZE-1:0] r_a;
  logic [SIZE-1:0] r_b;
  logic            r_cin;
  logic [SIZE-1:0] r_res_sum;
  logic            r_res_cout;
  logic            r_res_valid;
  logic            w_in_ready;
  logic            w_accept;
  logic            w_last_byte;
  logic            w_settle_done;
  logic            w_capture;

  // Both ports are valid/ready: a transfer happens on the rising edge where
  // valid && ready; the producer holds data stable while valid && !ready.
  assign w_accept      = in_valid && w_in_ready;
  assign w_last_byte   = (r_cnt == LAST_BYTE);
  assign w_settle_done = (r_settle == '0);
  assign w_capture     = (r_state == S_SETTLE) && w_settle_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_LOAD_A;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    case (r_state)
      S_LOAD_A: begin
        w_in_ready = 1'b1;
        if (w_accept && w_last_byte) w_next = S_LOAD_B;
      end
      S_LOAD_B: begin
        w_in_ready = 1'b1;
        if (w_accept && w_last_byte) w_next = S_LOAD_C;
      end
      S_LOAD_C: begin
        w_in_ready = 1'b1;
        if (w_accept) w_next = S_SETTLE;
      end
      S_SETTLE: if (w_settle_done) w_next = S_RESULT;
      S_RESULT: if (res_ready) w_next = S_LOAD_A;
      default:  w_next = S_LOAD_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_settle    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_cin       <= 1'b0;
      r_res_sum   <= '0;
      r_res_cout  <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD_A: if (w_accept) begin
          r_a[{r_cnt, 3'b000} +: 8] <= in_data;
          r_cnt <= w_last_byte ? '0 : r_cnt + 1'b1;
        end
        S_LOAD_B: if (w_accept) begin
          r_b[{r_cnt, 3'b000} +: 8] <= in_data;
          r_cnt <= w_last_byte ? '0 : r_cnt + 1'b1;
        end
        S_LOAD_C: if (w_accept) begin
          r_cin    <= in_data[0];
          r_settle <= SETTLE_LD;
        end
        S_SETTLE: begin
          if (w_settle_done) begin
            r_res_sum   <= add_sum;
            r_res_cout  <= add_cout;
            r_res_valid <= 1'b1;
          end else begin
            r_settle <= r_settle - 1'b1;
          end
        end
        S_RESULT: if (res_ready) r_res_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef ADDER_SELFCHECK_EN
  logic [SIZE:0] w_ref;
  logic          r_chk_err;

  assign w_ref = {1'b0, r_a} + {1'b0, r_b} + {{SIZE{1'b0}}, r_cin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           r_chk_err <= 1'b0;
    else if (w_capture && (w_ref != {add_cout, add_sum})) r_chk_err <= 1'b1;
  end

  assign chk_err = r_chk_err;
`else
  assign chk_err = 1'b0;
`endif

  assign in_ready  = w_in_ready;
  assign add_a     = r_a;
  assign add_b     = r_b;
  assign add_cin   = r_cin;
  assign res_sum   = r_res_sum;
  assign res_cout  = r_res_cout;
  assign res_valid = r_res_valid;
  assign busy      = !((r_state == S_LOAD_A) && (r_cnt == '0));
  assign dbg_state = r_state;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Randomized scoreboard bench for adder_operand_sequencer with a behavioural
// adder attached; results are predicted from the frame bytes themselves.
module tb_adder_operand_sequencer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_cout;
  logic [31:0] res_sum;
  logic        res_cout;
  logic        res_valid;
  logic        res_ready;
  logic        busy;
  logic        chk_err;
  logic [2:0]  dbg_state;

  adder_operand_sequencer #(.SIZE(32), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .res_sum(res_sum), .res_cout(res_cout),
    .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .chk_err(chk_err), .dbg_state(dbg_state)
  );

  // behavioural ripple adder, with an override to model a broken adder
  logic        corrupt;
  logic [32:0] w_adder;
  assign w_adder  = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
  assign add_sum  = corrupt ? 32'hDEADBEEF : w_adder[31:0];
  assign add_cout = corrupt ? 1'b0 : w_adder[32];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int cin_cyc = 0;
  bit auto_ready = 1'b1;
  bit prev_v = 1'b0;
  logic [32:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (auto_ready) res_ready = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n) begin
      if (res_valid && !prev_v) check("latency", 64'(cyc - cin_cyc), 64'd2);
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_result", 64'(res_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("result", {31'd0, res_cout, res_sum}, {31'd0, e});
        end
      end
    end
    prev_v = res_valid;
  end

  // driver tasks (called at posedge + 1)
  task automatic send_byte(input logic [7:0] b, output bit ok);
    in_data  = b;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("in_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] a, input logic [31:0] b,
                            input logic [7:0] c, input int start);
    logic [7:0] fr[9];
    bit ok;
    for (int i = 0; i < 4; i++) begin
      fr[i]     = a[8*i +: 8];
      fr[4 + i] = b[8*i +: 8];
    end
    fr[8] = c;
    for (int i = start; i < 9; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send_byte(fr[i], ok);
      if (!ok) return;
    end
    cin_cyc = cyc;
    if (corrupt) exp_q.push_back({1'b0, 32'hDEADBEEF});
    else         exp_q.push_back({1'b0, a} + {1'b0, b} + {32'd0, c[0]});
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    bit done = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (res_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("res_valid_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    logic [31:0] a, b, a2, b2, snap_sum;
    logic [7:0]  c, c2;
    bit ok;

    rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; res_ready = 1'b0; corrupt = 1'b0;
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_add_a", 64'(add_a), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    check("rst_chk_err", 64'(chk_err), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 1 + 1 with carry-in 0
    send_frame(32'h00000001, 32'h00000001, 8'h00, 0);
    wait_drain();

    // full carry ripple, cin byte with upper bits set
    send_frame(32'hFFFFFFFF, 32'h00000000, 8'hFF, 0);
    wait_drain();

    // randomized frames with random gaps and random res_ready
    for (int n = 0; n < 25; n++) begin
      case ($urandom_range(0, 3))
        0:       begin a = 32'hFFFFFFFF; b = $urandom; end
        1:       begin a = $urandom; b = ~a; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      c = 8'($urandom_range(0, 255));
      send_frame(a, b, c, 0);
    end
    wait_drain();

    // backpressure: result held while consumer stalls, input blocked
    auto_ready = 1'b0; res_ready = 1'b0;
    a = $urandom; b = $urandom; c = 8'h01;
    a2 = $urandom; b2 = $urandom; c2 = 8'($urandom_range(0, 255));
    send_frame(a, b, c, 0);
    wait_valid();
    snap_sum = a + b + 32'd1;
    in_data = a2[7:0]; in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("hold_valid", 64'(res_valid), 64'd1);
      check("hold_sum", 64'(res_sum), 64'(snap_sum));
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_add_a", 64'(add_a), 64'(a));
    end
    @(posedge clk); #1; res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
    @(negedge clk);
    check("release_valid", 64'(res_valid), 64'd0);
    check("release_in_ready", 64'(in_ready), 64'd1);
    check("release_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    send_frame(a2, b2, c2, 1);
    auto_ready = 1'b1;
    wait_drain();

    // reset mid-frame: partial bytes discarded
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(1, 255)), ok);
    @(negedge clk);
    check("midframe_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_res_valid", 64'(res_valid), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    check("async_add_a", 64'(add_a), 64'd0);
    check("async_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(32'h12345678, 32'h11111111, 8'h00, 0);
    wait_drain();

    // reset while a result is pending
    auto_ready = 1'b0; res_ready = 1'b0;
    send_frame($urandom, $urandom, 8'h01, 0);
    wait_valid();
    #2 rst_n = 1'b0;
    #1;
    check("rst_result_valid", 64'(res_valid), 64'd0);
    check("rst_result_sum", 64'(res_sum), 64'd0);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    auto_ready = 1'b1;
    send_frame(32'h80000000, 32'h80000000, 8'h00, 0);
    wait_drain();
    check("chk_err_clean", 64'(chk_err), 64'd0);

    // broken adder, then good frames
    corrupt = 1'b1;
    send_frame(32'h0, 32'h0, 8'h00, 0);
    wait_drain();
    corrupt = 1'b0;
    for (int n = 0; n < 2; n++) send_frame($urandom, $urandom, 8'($urandom_range(0, 255)), 0);
    wait_drain();
`ifdef ADDER_SELFCHECK_EN
    check("chk_err_sticky", 64'(chk_err), 64'd1);
`else
    check("chk_err_tied", 64'(chk_err), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule
